// File: rtl/key_pkg.sv
// Purpose : shared constants, types and helpers for the key remapper.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: key count, note width, default debounce length, identity map,
//           FSM state enum, permutation/one-hot helper functions.
package key_pkg;

  localparam int NUM_KEYS       = 8;
  localparam int NOTE_W         = 3;
  localparam int DEB_CYCLES_DEF = 4;

  typedef logic [NOTE_W-1:0]          note_t;
  typedef note_t [NUM_KEYS-1:0]       map_t;

  localparam map_t IDENTITY_MAP = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // With 8 entries of 3 bits, "pairwise distinct" is the same as "every note
  // value appears", so a coverage bitmap is enough.
  function automatic logic perm_distinct(input map_t p);
    logic [NUM_KEYS-1:0] seen;
    seen = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      seen[p[k]] = 1'b1;
    end
    return &seen;
  endfunction

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Only meaningful when v is one-hot.
  function automatic note_t onehot_idx(input logic [NUM_KEYS-1:0] v);
    note_t r;
    r = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (v[k]) r = note_t'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose : 2-flop synchronizer plus counting debouncer for one key.
// Latency : clean raw edge reaches o_level after DEB_CYCLES+2 cycles.
// Backpressure: none; free-running sampler.
// Ports   : i_clk, i_rst (sync, active-high), i_raw (async key level),
//           o_level (debounced level).
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF  // legal range 2..255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the accepted level restarts the count, so
      // only an unbroken run of DEB_CYCLES differing samples flips the level.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == 8'(DEB_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/key_remap.sv
// Purpose : debounce 8 keys, track a single held key and emit its remapped note.
// Latency : raw press/release to note_on/note_off is DEB_CYCLES+3 cycles.
// Backpressure: none; pulses are single-cycle and unacknowledged.
// Ports   : i_slow_clk, i_rst (sync, active-high), i_raw_keys[7:0],
//           i_perm0..7 + i_perm_load (new map request), o_note_idx,
//           o_note_valid, o_note_on, o_note_off, o_perm_err.
module key_remap
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                i_slow_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_raw_keys,
  input  logic [NOTE_W-1:0]   i_perm0,
  input  logic [NOTE_W-1:0]   i_perm1,
  input  logic [NOTE_W-1:0]   i_perm2,
  input  logic [NOTE_W-1:0]   i_perm3,
  input  logic [NOTE_W-1:0]   i_perm4,
  input  logic [NOTE_W-1:0]   i_perm5,
  input  logic [NOTE_W-1:0]   i_perm6,
  input  logic [NOTE_W-1:0]   i_perm7,
  input  logic                i_perm_load,
  output logic [NOTE_W-1:0]   o_note_idx,
  output logic                o_note_valid,
  output logic                o_note_on,
  output logic                o_note_off,
  output logic                o_perm_err
);

  logic [NUM_KEYS-1:0] w_deb;
  map_t                w_perm;
  logic                w_onehot;
  note_t               w_key;

  state_e r_state;
  note_t  r_hk;
  map_t   r_map;
  note_t  r_note_idx;
  logic   r_note_valid;
  logic   r_note_on;
  logic   r_note_off;
  logic   r_perm_err;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_slow_clk),
      .i_rst   (i_rst),
      .i_raw   (i_raw_keys[k]),
      .o_level (w_deb[k])
    );
  end

  assign w_perm   = {i_perm7, i_perm6, i_perm5, i_perm4,
                     i_perm3, i_perm2, i_perm1, i_perm0};
  assign w_onehot = is_onehot(w_deb);
  assign w_key    = onehot_idx(w_deb);

  always_ff @(posedge i_slow_clk) begin
    if (i_rst) begin
      // Reset wins over everything, including a coincident perm_load and
      // the note_off a held key would otherwise produce.
      r_state      <= ST_IDLE;
      r_hk         <= '0;
      r_map        <= IDENTITY_MAP;
      r_note_idx   <= '0;
      r_note_valid <= 1'b0;
      r_note_on    <= 1'b0;
      r_note_off   <= 1'b0;
      r_perm_err   <= 1'b0;
    end else begin
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_perm_err <= 1'b0;

      if (i_perm_load) begin
        if (perm_distinct(w_perm)) r_map <= w_perm;
        else                       r_perm_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // r_map is read before any same-cycle load takes effect, so a
          // coincident load only affects later notes.
          if (w_onehot) begin
            r_hk         <= w_key;
            r_note_idx   <= r_map[w_key];
            r_note_valid <= 1'b1;
            r_note_on    <= 1'b1;
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Only the held key matters here; other keys are ignored.
          if (!w_deb[r_hk]) begin
            r_note_valid <= 1'b0;
            r_note_off   <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_note_idx   = r_note_idx;
  assign o_note_valid = r_note_valid;
  assign o_note_on    = r_note_on;
  assign o_note_off   = r_note_off;
  assign o_perm_err   = r_perm_err;

endmodule

// File: tb/tb_key_remap.sv
module tb_key_remap;
  import key_pkg::*;

  localparam int K_ON  = 0;
  localparam int K_OFF = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic [2:0] p [8];
  logic       perm_load;
  logic [2:0] note_idx;
  logic       note_valid;
  logic       note_on;
  logic       note_off;
  logic       perm_err;

  evt_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_remap #(.DEB_CYCLES(4)) dut (
    .i_slow_clk   (clk),
    .i_rst        (rst),
    .i_raw_keys   (raw),
    .i_perm0      (p[0]),
    .i_perm1      (p[1]),
    .i_perm2      (p[2]),
    .i_perm3      (p[3]),
    .i_perm4      (p[4]),
    .i_perm5      (p[5]),
    .i_perm6      (p[6]),
    .i_perm7      (p[7]),
    .i_perm_load  (perm_load),
    .o_note_idx   (note_idx),
    .o_note_valid (note_valid),
    .o_note_on    (note_on),
    .o_note_off   (note_off),
    .o_perm_err   (perm_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_evt(input int kind, input int at, input int idx);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    e.idx  = idx;
    q.push_back(e);
  endtask

  // Pull the oldest expected event of this kind and compare it with what the
  // DUT just produced; an event nobody expected is reported against cycle -1.
  task automatic match_evt(input int kind, input string name);
    int   pos;
    evt_t e;
    pos = -1;
    foreach (q[i]) if (pos < 0 && q[i].kind == kind) pos = i;
    if (pos < 0) begin
      check_eq({"spurious_", name}, 32'(cyc), 32'hFFFF_FFFF);
    end else begin
      e = q[pos];
      q.delete(pos);
      check_eq({name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      if (kind != K_ERR) begin
        check_eq({name, "_idx"}, 32'(note_idx), 32'(e.idx));
        check_eq({name, "_valid"}, 32'(note_valid), (kind == K_ON) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (perm_err === 1'b1) match_evt(K_ERR, "perm_err");
      if (note_on  === 1'b1) match_evt(K_ON,  "note_on");
      if (note_off === 1'b1) match_evt(K_OFF, "note_off");
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(note_valid), 32'd0);
    check_eq({tag, "_idx"},   32'(note_idx),   32'd0);
    check_eq({tag, "_on"},    32'(note_on),    32'd0);
    check_eq({tag, "_off"},   32'(note_off),   32'd0);
    check_eq({tag, "_err"},   32'(perm_err),   32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    check_reset_state("rst");
    rst = 1'b0;
    tick(2);
  endtask

  // mode 0: reversed, 1: rotate by one, 2: rotate by five, 3: duplicate entries
  task automatic set_perm(input int mode);
    int dup [8] = '{3, 3, 5, 4, 0, 2, 1, 7};
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       p[k] = 3'(7 - k);
        1:       p[k] = 3'((k + 1) % 8);
        2:       p[k] = 3'((k + 5) % 8);
        default: p[k] = 3'(dup[k]);
      endcase
    end
  endtask

  task automatic load_perm(input int mode);
    set_perm(mode);
    perm_load = 1'b1;
    tick(1);
    perm_load = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    raw       = 8'h00;
    perm_load = 1'b0;
    for (int k = 0; k < 8; k++) p[k] = 3'(k);
    tick(2);
    check_reset_state("init");
    rst = 1'b0;
    tick(2);

    // Single key 2: note_on/off exactly 7 cycles after the raw edges.
    raw = 8'h04; push_evt(K_ON, cyc + 7, 2);
    tick(10);
    check_eq("hold_valid", 32'(note_valid), 32'd1);
    check_eq("hold_idx",   32'(note_idx),   32'd2);
    tick(10);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 2);
    tick(6);
    check_eq("rel_plus6_valid", 32'(note_valid), 32'd1);
    tick(1);
    check_eq("rel_plus7_valid", 32'(note_valid), 32'd0);
    tick(5);

    // Rejected permutation: one perm_err pulse, map stays identity.
    set_perm(3);
    push_evt(K_ERR, cyc + 1, 0);
    load_perm(3);
    tick(3);
    raw = 8'h02; push_evt(K_ON, cyc + 7, 1);
    tick(12);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 1);
    tick(12);

    // Accepted reversed permutation: key 1 -> note 6, no error.
    load_perm(0);
    tick(3);
    raw = 8'h02; push_evt(K_ON, cyc + 7, 6);
    tick(12);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 6);
    tick(12);

    // Glitch of 3 cycles on key 4 must not be accepted.
    do_reset();
    raw = 8'h10;
    tick(3);
    raw = 8'h00;
    tick(15);
    check_eq("glitch_valid", 32'(note_valid), 32'd0);

    // Two keys together: no note. Then key 0 held and key 5 added.
    raw = 8'h21;
    tick(15);
    check_eq("multihot_valid", 32'(note_valid), 32'd0);
    raw = 8'h00;
    tick(15);
    raw = 8'h01; push_evt(K_ON, cyc + 7, 0);
    tick(10);
    raw = 8'h21;
    tick(15);
    check_eq("other_key_idx",   32'(note_idx),   32'd0);
    check_eq("other_key_valid", 32'(note_valid), 32'd1);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 0);
    tick(12);

    // Load during HOLD changes the map but not the current note.
    raw = 8'h08; push_evt(K_ON, cyc + 7, 3);
    tick(10);
    load_perm(0);
    tick(2);
    check_eq("hold_load_idx", 32'(note_idx), 32'd3);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 3);
    tick(12);
    raw = 8'h08; push_evt(K_ON, cyc + 7, 4);
    tick(10);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 4);
    tick(12);

    // Load coinciding with IDLE->HOLD: the old (identity) map is used.
    do_reset();
    raw = 8'h04; push_evt(K_ON, cyc + 7, 2);
    tick(6);
    load_perm(1);
    tick(5);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 2);
    tick(12);
    raw = 8'h04; push_evt(K_ON, cyc + 7, 3);
    tick(10);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 3);
    tick(12);
    raw = 8'h08; push_evt(K_ON, cyc + 7, 4);
    tick(10);

    // Reset while holding key 3, with a coincident (ignored) perm_load.
    set_perm(2);
    perm_load = 1'b1;
    rst       = 1'b1;
    tick(1);
    check_reset_state("hold_rst");
    rst       = 1'b0;
    perm_load = 1'b0;
    push_evt(K_ON, cyc + 7, 3);
    tick(10);
    raw = 8'h00; push_evt(K_OFF, cyc + 7, 3);
    tick(12);

    check_eq("pending_events", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_remap.md
KEY_REMAP -- requirements
Module: key_remap

Interface
REQ-001 Parameter DEB_CYCLES, default 4, sets the number of consecutive stable synchronized samples needed to accept a key level change (range 2..255).
REQ-002 slow_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 raw_keys  input  8  asynchronous physical key levels, bit k = key k, 1 = pressed.
REQ-005 perm0..perm7  input  3 each  candidate mapping, key k -> note permk.
REQ-006 perm_load  input  1  single-cycle request to adopt perm0..perm7.
REQ-007 note_idx  output  3  mapped note of the held key.
REQ-008 note_valid  output  1  high while a mapped note is held.
REQ-009 note_on  output  1  one-cycle pulse when a note starts.
REQ-010 note_off  output  1  one-cycle pulse when a note ends.
REQ-011 perm_err  output  1  one-cycle pulse when perm_load is rejected.

Function
REQ-012 Each raw_keys bit SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-013 Debouncer: the counter resets to 0 on any cycle where the synchronized level equals the debounced level; otherwise it increments; when it reaches DEB_CYCLES-1 the debounced level flips and the counter clears.
REQ-014 A clean raw edge SHALL change the debounced level exactly DEB_CYCLES+2 cycles later; a pulse shorter than DEB_CYCLES synchronized cycles SHALL never change it.
REQ-015 Mapping table map[0..7] (3 bits each) SHALL be registered and hold the identity 0..7 after reset.
REQ-016 On perm_load, if perm0..perm7 are pairwise distinct, map[k] <= permk in the next cycle; otherwise map is unchanged and perm_err pulses the next cycle.
REQ-017 FSM states: IDLE, HOLD; a held-key register hk[2:0].
REQ-018 IDLE -> HOLD only when the debounced vector is exactly one-hot with bit k set: hk <= k, note_idx <= map[k], note_valid <= 1, note_on pulses, all in the next cycle.
REQ-019 In IDLE, a zero or multi-hot debounced vector SHALL cause no transition and no pulse.
REQ-020 HOLD -> IDLE when debounced bit hk falls: note_valid <= 0, note_off pulses in the next cycle; note_idx retains its last value.
REQ-021 In HOLD, changes on other keys SHALL be ignored; no new note_on until return to IDLE.
REQ-022 A perm_load accepted during HOLD SHALL update map but not note_idx; the new map applies from the next IDLE -> HOLD transition.
REQ-023 If perm_load coincides with an IDLE -> HOLD transition, note_idx SHALL use the old map.
REQ-024 End-to-end latency: clean raw press to note_on = DEB_CYCLES+3 cycles; same latency for release to note_off.

Reset
REQ-025 On rst: state IDLE, hk=0, note_idx=0, note_valid=0, note_on=0, note_off=0, perm_err=0, map=identity, synchronizers, debounced levels and counters 0.
REQ-026 Reset during HOLD SHALL NOT produce a note_off pulse.
REQ-027 A perm_load asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-028 Shared package key_pkg SHALL hold NUM_KEYS=8, NOTE_W=3, DEB_CYCLES default, the identity-map constant and the FSM state enum.
REQ-029 Per-key synchronizer plus debouncer SHALL be one sub-module, key_debounce, instantiated NUM_KEYS times.

Verification (DEB_CYCLES=4)
REQ-030 After reset, raw_keys=8'b00000100 held for 20 cycles -> note_on at press+7, note_idx=2, note_valid=1; on release -> note_off at release+7, note_valid=0.
REQ-031 perm_load with perm0..7=7,6,5,4,3,2,1,0, then key 1 pressed -> note_idx=6, perm_err stays 0.
REQ-032 perm_load with perm0..7=3,3,5,4,0,2,1,7 -> perm_err pulses once; key 1 pressed -> note_idx=1.
REQ-033 Key 4 high for 3 cycles only -> no note_on, note_valid stays 0.
REQ-034 Keys 0 and 5 rise together -> no note_on; key 0 held, then key 5 pressed -> note_idx stays 0, exactly one note_on.
REQ-035 rst asserted in HOLD with key 3 held -> next cycle note_valid=0, note_off=0, map identity.
